// File: rtl/mipi_pixel_tx.sv
// Parallel pixel transmitter producing pixel_d/hs/vs camera-capture timing from a
// valid/ready pixel stream or an internal test pattern, with sticky stream error flags.
module mipi_pixel_tx #(
  parameter int DATA_W   = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_PRE    = 2,
  parameter int V_ACTIVE = 480,
  parameter int V_POST   = 10,
  parameter logic [DATA_W-1:0] FILL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  input  logic              clear_status,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] pixel_d,
  output logic              pixel_hs,
  output logic              pixel_vs,
  output logic              underflow,
  output logic              sof_err,
  output logic [15:0]       frame_count,
  output logic [1:0]        dbg_state
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_PRE + V_ACTIVE + V_POST + 1);
  localparam int AW      = $clog2(H_ACTIVE);

  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, ACT = 2'd2, POST = 2'd3} state_t;

  state_t            state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [1:0]        pat;
  logic [YW-1:0]     last_y;
  logic              x_active;
  logic              line_end;
  logic              act_pix;
  logic              vs_next;
  logic              first_pix;
  logic              uf_hit;
  logic              sof_bad;
  logic [2:0]        bar_idx;
  logic [DATA_W-1:0] pix_next;

  assign x_active  = (x < XW'(H_ACTIVE));
  assign line_end  = (x == XW'(H_TOTAL - 1));
  assign act_pix   = (state == ACT) && x_active;
  assign vs_next   = (state == PRE) || (state == ACT);
  assign first_pix = (x == '0) && (y == '0);
  assign dbg_state = state;

  // Stream handshake: a pixel transfers on a rising edge where s_valid & s_ready.
  // s_ready is high on every active cycle of a stream-mode frame and never waits on
  // s_valid; an active cycle without s_valid is lost to FILL and flagged as underflow.
  assign s_ready = act_pix && (pat == 2'd0);
  assign uf_hit  = s_ready && !s_valid;
  assign sof_bad = s_valid && s_ready && (s_sof != first_pix);

  // Bars use the top three bits of the active-pixel index; narrow lines scale up.
  if (AW >= 3) begin : g_bar_hi
    assign bar_idx = x[AW-1 -: 3];
  end else begin : g_bar_lo
    assign bar_idx = 3'(x) << (3 - AW);
  end

  always_comb begin
    pix_next = '0;
    if (act_pix) begin
      case (pat)
        2'd0:    pix_next = s_valid ? s_data : FILL;
        2'd1:    pix_next = {bar_idx, {(DATA_W-3){1'b1}}};
        2'd2:    pix_next = DATA_W'(x) + DATA_W'(y);
        default: pix_next = FILL;
      endcase
    end
  end

  always_comb begin
    last_y = '0;
    case (state)
      PRE:     last_y = YW'(V_PRE - 1);
      ACT:     last_y = YW'(V_ACTIVE - 1);
      POST:    last_y = YW'(V_POST - 1);
      default: last_y = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      pat         <= 2'd0;
      pixel_d     <= '0;
      pixel_hs    <= 1'b0;
      pixel_vs    <= 1'b0;
      underflow   <= 1'b0;
      sof_err     <= 1'b0;
      frame_count <= '0;
    end else begin
      pixel_d  <= pix_next;
      pixel_hs <= act_pix;
      pixel_vs <= vs_next;
      if (pixel_vs && !vs_next) frame_count <= frame_count + 16'd1;

      if (uf_hit)            underflow <= 1'b1;
      else if (clear_status) underflow <= 1'b0;
      if (sof_bad)           sof_err   <= 1'b1;
      else if (clear_status) sof_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (enable) begin
            state <= PRE;
            pat   <= pattern_sel;
            x     <= '0;
            y     <= '0;
          end
        end
        default: begin
          if (!line_end) begin
            x <= x + XW'(1);
          end else begin
            x <= '0;
            if (y != last_y) begin
              y <= y + YW'(1);
            end else begin
              y <= '0;
              case (state)
                PRE: state <= ACT;
                ACT: state <= POST;
                default: begin
                  if (enable) begin
                    state <= PRE;
                    pat   <= pattern_sel;
                  end else begin
                    state <= IDLE;
                  end
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_pixel_tx.sv
// Bench for mipi_pixel_tx: frame-level reference model feeds an expected-pixel queue,
// a monitor checks pixels and hs/vs widths, frame tasks check flags and idle state.
`timescale 1ns/1ps
module tb_mipi_pixel_tx;
  localparam int DATA_W   = 10;
  localparam int H_ACTIVE = 4;
  localparam int H_BLANK  = 2;
  localparam int V_PRE    = 1;
  localparam int V_ACTIVE = 2;
  localparam int V_POST   = 1;
  localparam logic [DATA_W-1:0] FILL = 10'h155;
  localparam int H_TOTAL  = H_ACTIVE + H_BLANK;
  localparam int VS_LEN   = (V_PRE + V_ACTIVE) * H_TOTAL;
  localparam int FRAME_T  = (V_PRE + V_ACTIVE + V_POST) * H_TOTAL;
  localparam int NPIX     = H_ACTIVE * V_ACTIVE;

  typedef struct packed {
    logic              valid;
    logic              sof;
    logic              clr;
    logic [DATA_W-1:0] data;
  } desc_t;

  // clock/reset and DUT signals
  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic [1:0]        pattern_sel = 2'd0;
  logic              clear_status = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_sof = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] pixel_d;
  logic              pixel_hs;
  logic              pixel_vs;
  logic              underflow;
  logic              sof_err;
  logic [15:0]       frame_count;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] exp_q[$];
  desc_t             desc_q[$];
  desc_t             plan_q[$];

  int          n_vec = 0;
  int          n_err = 0;
  int          vs_rises = 0;
  int          vs_falls = 0;
  int          hs_rises = 0;
  int          cyc = 0;
  logic        uf_m = 1'b0;
  logic        se_m = 1'b0;
  logic        clr_req = 1'b0;
  logic [15:0] fc_exp = '0;

  always #5 clk = ~clk;

  mipi_pixel_tx #(
    .DATA_W(DATA_W), .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_PRE(V_PRE),
    .V_ACTIVE(V_ACTIVE), .V_POST(V_POST), .FILL(FILL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
    .clear_status(clear_status), .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid),
    .s_ready(s_ready), .pixel_d(pixel_d), .pixel_hs(pixel_hs), .pixel_vs(pixel_vs),
    .underflow(underflow), .sof_err(sof_err), .frame_count(frame_count),
    .dbg_state(dbg_state)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_event(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: event not seen, required within cycle budget", nm);
  endtask

  // reference model: expected output pixels of one frame in raster order
  task automatic push_frame(input logic [1:0] pat);
    desc_t d;
    int    x, y, bar;
    for (int k = 0; k < NPIX; k++) begin
      x = k % H_ACTIVE;
      y = k / H_ACTIVE;
      case (pat)
        2'd0: begin
          d = plan_q.pop_front();
          desc_q.push_back(d);
          exp_q.push_back(d.valid ? d.data : FILL);
          if (!d.valid) uf_m = 1'b1;
          else if (d.clr) uf_m = 1'b0;
          if (d.valid && (d.sof != (k == 0))) se_m = 1'b1;
          else if (d.clr) se_m = 1'b0;
        end
        2'd1: begin
          bar = (x * 8) / H_ACTIVE;
          exp_q.push_back(DATA_W'(bar * (1 << (DATA_W-3)) + (1 << (DATA_W-3)) - 1));
        end
        2'd2:    exp_q.push_back(DATA_W'(x + y));
        default: exp_q.push_back(FILL);
      endcase
    end
  endtask

  task automatic plan_directed(input logic [DATA_W-1:0] base, input int inv_k,
                               input int sof_k, input int clr_k);
    desc_t d;
    for (int k = 0; k < NPIX; k++) begin
      d.valid = (k != inv_k);
      d.sof   = (k == 0) ^ (k == sof_k);
      d.clr   = (k == clr_k);
      d.data  = DATA_W'(base + DATA_W'(k));
      plan_q.push_back(d);
    end
  endtask

  task automatic plan_random();
    desc_t d;
    for (int k = 0; k < NPIX; k++) begin
      d.valid = ($urandom_range(0, 9) != 0);
      d.sof   = (k == 0) ^ ($urandom_range(0, 15) == 0);
      d.clr   = ($urandom_range(0, 9) == 0);
      d.data  = DATA_W'($urandom);
      plan_q.push_back(d);
    end
  endtask

  // run n back-to-back frames, drop enable in the first line of the last one
  task automatic frames(input logic [1:0] pat, input int n);
    int r0, f0, h0, t;
    for (int f = 0; f < n; f++) push_frame(pat);
    r0 = vs_rises;
    f0 = vs_falls;
    @(negedge clk);
    pattern_sel = pat;
    enable = 1'b1;
    t = 0;
    while (vs_rises < r0 + n && t < n * FRAME_T + 50) begin @(negedge clk); t++; end
    if (vs_rises < r0 + n) fail_event("vs_rise");
    h0 = hs_rises;
    t = 0;
    while (hs_rises == h0 && t < FRAME_T) begin @(negedge clk); t++; end
    if (hs_rises == h0) fail_event("hs_rise");
    enable = 1'b0;
    t = 0;
    while (vs_falls < f0 + n && t < 2 * FRAME_T) begin @(negedge clk); t++; end
    if (vs_falls < f0 + n) fail_event("vs_fall");
    repeat (H_TOTAL * V_POST + 3) @(negedge clk);
    fc_exp = fc_exp + 16'(n);
    check("idle_state", 32'(dbg_state), 32'(0));
    check("idle_vs", 32'(pixel_vs), 32'(0));
    check("idle_hs", 32'(pixel_hs), 32'(0));
    check("idle_ready", 32'(s_ready), 32'(0));
    check("frame_count", 32'(frame_count), 32'(fc_exp));
    check("underflow", 32'(underflow), 32'(uf_m));
    check("sof_err", 32'(sof_err), 32'(se_m));
    check("exp_left", 32'(exp_q.size()), 32'(0));
    check("desc_left", 32'(desc_q.size()), 32'(0));
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clr_req = 1'b1;
    repeat (2) @(negedge clk);
    clr_req = 1'b0;
    @(negedge clk);
    uf_m = 1'b0;
    se_m = 1'b0;
    check("clr_underflow", 32'(underflow), 32'(0));
    check("clr_sof_err", 32'(sof_err), 32'(0));
  endtask

  // stream driver: presents the head descriptor, retires it after a ready cycle
  initial begin
    desc_t d;
    logic  consumed;
    consumed = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) consumed = 1'b0;
      if (consumed && desc_q.size() > 0) void'(desc_q.pop_front());
      if (desc_q.size() > 0) begin
        d = desc_q[0];
        s_valid = d.valid;
        s_sof   = d.sof;
        s_data  = d.data;
        clear_status = clr_req | (d.clr & s_ready);
      end else begin
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = '0;
        clear_status = clr_req;
      end
      consumed = s_ready;
    end
  end

  // monitor: pixel scoreboard and hs/vs width/period checks
  initial begin
    int                vs_len, hs_len, last_rise;
    logic              pvs, phs;
    logic [DATA_W-1:0] e;
    vs_len = 0; hs_len = 0; last_rise = -100000; pvs = 1'b0; phs = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        vs_len = 0; hs_len = 0; last_rise = -100000; pvs = 1'b0; phs = 1'b0;
      end else begin
        if (pixel_hs) begin
          hs_len++;
          if (!phs) hs_rises++;
          check("hs_in_vs", 32'(pixel_vs), 32'(1));
          if (exp_q.size() == 0) fail_event("pixel_unexpected");
          else begin
            e = exp_q.pop_front();
            check("pixel_d", 32'(pixel_d), 32'(e));
          end
        end else begin
          if (phs) begin
            check("hs_width", 32'(hs_len), 32'(H_ACTIVE));
            hs_len = 0;
          end
          check("blank_d", 32'(pixel_d), 32'(0));
        end
        if (pixel_vs) begin
          vs_len++;
          if (!pvs) begin
            if (cyc - last_rise <= FRAME_T + 2)
              check("frame_period", 32'(cyc - last_rise), 32'(FRAME_T));
            last_rise = cyc;
            vs_rises++;
          end
        end else if (pvs) begin
          check("vs_width", 32'(vs_len), 32'(VS_LEN));
          vs_len = 0;
          vs_falls++;
        end
        pvs = pixel_vs;
        phs = pixel_hs;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int t, h0;
    repeat (3) @(negedge clk);
    check("rst_d", 32'(pixel_d), 32'(0));
    check("rst_hs", 32'(pixel_hs), 32'(0));
    check("rst_vs", 32'(pixel_vs), 32'(0));
    check("rst_ready", 32'(s_ready), 32'(0));
    check("rst_uf", 32'(underflow), 32'(0));
    check("rst_sof", 32'(sof_err), 32'(0));
    check("rst_fc", 32'(frame_count), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    frames(2'd2, 2);
    frames(2'd1, 1);
    frames(2'd3, 1);

    plan_directed(10'h100, -1, -1, -1); frames(2'd0, 1);
    plan_directed(10'h200, 2, -1, -1);  frames(2'd0, 1);
    clear_flags();
    plan_directed(10'h300, 5, -1, 5);   frames(2'd0, 1);
    plan_directed(10'h040, -1, -1, 6);  frames(2'd0, 1);
    plan_directed(10'h050, -1, 0, -1);  frames(2'd0, 1);
    clear_flags();
    plan_directed(10'h060, -1, 3, -1);  frames(2'd0, 1);
    clear_flags();

    for (int r = 0; r < 3; r++) begin
      plan_random();
      plan_random();
      frames(2'd0, 2);
    end
    for (int r = 0; r < 4; r++) begin
      pattern_sel = 2'($urandom_range(0, 3));
      if (pattern_sel == 2'd0) plan_random();
      frames(pattern_sel, 1);
    end

    // asynchronous reset in the middle of an active line
    push_frame(2'd2);
    @(negedge clk);
    pattern_sel = 2'd2;
    enable = 1'b1;
    h0 = hs_rises;
    t = 0;
    while (hs_rises == h0 && t < 2 * FRAME_T) begin @(negedge clk); t++; end
    if (hs_rises == h0) fail_event("hs_before_reset");
    #3 reset_n = 1'b0;
    #1;
    check("arst_hs", 32'(pixel_hs), 32'(0));
    check("arst_vs", 32'(pixel_vs), 32'(0));
    check("arst_d", 32'(pixel_d), 32'(0));
    check("arst_state", 32'(dbg_state), 32'(0));
    exp_q.delete();
    desc_q.delete();
    uf_m = 1'b0;
    se_m = 1'b0;
    fc_exp = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("arst_fc", 32'(frame_count), 32'(0));
    frames(2'd2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
